// File: rtl/kgp_mem_pkg.sv
// Shared definitions for the KGP-miniRISC data-memory path: responder states,
// word geometry and the legal-address check used at request accept.
package kgp_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;

    // Misaligned byte addresses and anything above the top RAM word are rejected; nothing aliases.
    function automatic logic addr_err(input logic [31:0] addr, input int addrWidth);
        logic [31:0] highBits;
        logic        misaligned;
        misaligned = (addr & 32'(WORD_BYTES - 1)) != 32'd0;
        highBits   = addr >> (addrWidth + 2);
        return misaligned || (highBits != 32'd0);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM. Read data appears after the enabling edge
// and is held until the next enabled read; contents are never reset.
module dmem_array
    import kgp_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Responder end of the core's dmem interface: one request at a time, a fixed
// number of wait states, then a held response carrying load data or an error.
module dmem_responder
    import kgp_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err
);

    localparam logic NO_WAIT = (WAIT_STATES == 0);

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  respValid_q;
    logic                  respErr_q;
    logic                  loadResp_q;

    logic                  accept;
    logic                  reqErr;
    logic [ADDR_WIDTH-1:0] reqWord;
    logic                  immAccess;
    logic                  waitAccess;
    logic                  ramEn;
    logic                  ramWe;
    logic [ADDR_WIDTH-1:0] ramAddr;
    logic [DATA_WIDTH-1:0] ramWdata;
    logic [DATA_WIDTH-1:0] ramRdata;

    assign req_ready  = (state_q == IDLE) && !rst;
    assign accept     = req_valid && req_ready;
    assign reqErr     = addr_err(req_addr, ADDR_WIDTH);
    assign reqWord    = req_addr[ADDR_WIDTH+1:2];

    // With no wait states the access goes straight from the request port on the accept edge.
    assign immAccess  = accept && !reqErr && NO_WAIT;
    assign waitAccess = (state_q == WAIT) && (cnt_q == 4'd0);
    assign ramEn      = !rst && (immAccess || waitAccess);
    assign ramWe      = immAccess ? req_write : write_q;
    assign ramAddr    = immAccess ? reqWord   : addr_q;
    assign ramWdata   = immAccess ? req_wdata : wdata_q;

    dmem_array #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_array (
        .clk  (clk),
        .en   (ramEn),
        .we   (ramWe),
        .addr (ramAddr),
        .wdata(ramWdata),
        .rdata(ramRdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            respValid_q <= 1'b0;
            respErr_q   <= 1'b0;
            loadResp_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        write_q <= req_write;
                        addr_q  <= reqWord;
                        wdata_q <= req_wdata;
                        if (reqErr) begin
                            state_q     <= RESP;
                            respValid_q <= 1'b1;
                            respErr_q   <= 1'b1;
                            loadResp_q  <= 1'b0;
                        end else if (NO_WAIT) begin
                            state_q     <= RESP;
                            respValid_q <= 1'b1;
                            respErr_q   <= 1'b0;
                            loadResp_q  <= !req_write;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 4'(WAIT_STATES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= RESP;
                        respValid_q <= 1'b1;
                        respErr_q   <= 1'b0;
                        loadResp_q  <= !write_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q     <= IDLE;
                        respValid_q <= 1'b0;
                        respErr_q   <= 1'b0;
                        loadResp_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Load data is the RAM's own output register, which stays put until the next enabled read.
    assign resp_valid = respValid_q;
    assign resp_err   = respErr_q;
    assign resp_rdata = loadResp_q ? ramRdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a table of load/store vectors with a scoreboard queue on a
// two-wait-state instance, plus stall, reset and zero-wait-state sequences.
module tb_dmem_responder;

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        reqValid = 1'b0;
    logic        respReady = 1'b0;
    logic        reqWrite = 1'b0;
    logic [31:0] reqAddr = 32'd0;
    logic [31:0] reqWdata = 32'd0;

    logic        reqValid2, respReady2, reqReady2, respValid2, respErr2;
    logic        reqValid0, respReady0, reqReady0, respValid0, respErr0;
    logic [31:0] respRdata2, respRdata0;
    logic        curReady, curValid, curErr;
    logic [31:0] curRdata;

    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];
    vec_t vecs[13];

    always #5 clk = ~clk;

    assign reqValid2  = reqValid && !sel;
    assign respReady2 = respReady && !sel;
    assign reqValid0  = reqValid && sel;
    assign respReady0 = respReady && sel;
    assign curReady   = sel ? reqReady0  : reqReady2;
    assign curValid   = sel ? respValid0 : respValid2;
    assign curErr     = sel ? respErr0   : respErr2;
    assign curRdata   = sel ? respRdata0 : respRdata2;

    dmem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid2), .req_ready(reqReady2), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .resp_valid(respValid2), .resp_ready(respReady2),
        .resp_rdata(respRdata2), .resp_err(respErr2)
    );

    dmem_responder #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req_valid(reqValid0), .req_ready(reqReady0), .req_write(reqWrite),
        .req_addr(reqAddr), .req_wdata(reqWdata),
        .resp_valid(respValid0), .resp_ready(respReady0),
        .resp_rdata(respRdata0), .resp_err(respErr0)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, want %h", name, actual, expected);
        end
    endtask

    // Presents a request until it is accepted and queues what the response must look like.
    task automatic applyStimulus(input logic write, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expErr, input int expLat);
        exp_t e;
        bit   readySeen;
        int   guard;
        e.rdata = expRdata;
        e.err   = expErr;
        e.lat   = expLat;
        sbq.push_back(e);
        reqWrite = write;
        reqAddr  = addr;
        reqWdata = wdata;
        reqValid = 1'b1;
        guard    = 0;
        do begin
            readySeen = curReady;
            @(posedge clk);
            #1;
            guard++;
        end while (!readySeen && guard < 20);
        reqValid = 1'b0;
        if (!readySeen) checkOutput("acceptTimeout", 32'd0, 32'd1);
    endtask

    // Counts edges from the accept edge (inclusive) to resp_valid, compares against the queue,
    // optionally stalls with req_valid pulses, then completes the handshake.
    task automatic collectResponse(input int holdCycles, input bit presentNext);
        exp_t        e;
        int          edges;
        logic [31:0] heldRdata;
        logic        heldErr;
        edges = 1;
        while (!curValid && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (sbq.size() == 0) begin
            checkOutput("scoreboardEmpty", 32'd1, 32'd0);
            return;
        end
        e = sbq.pop_front();
        checkOutput("respLatency", 32'(edges), 32'(e.lat));
        checkOutput("respRdata", curRdata, e.rdata);
        checkOutput("respErr", 32'(curErr), 32'(e.err));
        heldRdata = curRdata;
        heldErr   = curErr;
        for (int i = 0; i < holdCycles; i++) begin
            reqValid = (i % 2 == 0);
            @(posedge clk);
            #1;
            checkOutput("stallValid", 32'(curValid), 32'd1);
            checkOutput("stallRdata", curRdata, heldRdata);
            checkOutput("stallErr", 32'(curErr), 32'(heldErr));
            checkOutput("stallReady", 32'(curReady), 32'd0);
        end
        reqValid  = presentNext;
        respReady = 1'b1;
        @(posedge clk);
        #1;
        respReady = 1'b0;
        checkOutput("respCleared", 32'(curValid), 32'd0);
        checkOutput("rdataCleared", curRdata, 32'd0);
        checkOutput("readyAfterResp", 32'(curReady), 32'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0000, 32'hA5A5_0000, 32'h0000_0000, 1'b0, 3};
        vecs[1]  = '{1'b1, 32'h0000_0020, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 3};
        vecs[2]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 3};
        vecs[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[4]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[5]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 3};
        vecs[6]  = '{1'b1, 32'h0000_1000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1};
        vecs[7]  = '{1'b1, 32'h0000_0FFC, 32'h1234_5678, 32'h0000_0000, 1'b0, 3};
        vecs[8]  = '{1'b0, 32'h0000_0FFC, 32'h0000_0000, 32'h1234_5678, 1'b0, 3};
        vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 32'hA5A5_0000, 1'b0, 3};
        vecs[10] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[11] = '{1'b0, 32'h0000_0002, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};
        vecs[12] = '{1'b0, 32'h0000_1004, 32'h0000_0000, 32'h0000_0000, 1'b1, 1};

        // Reset values while rst is held on both instances.
        #2;
        checkOutput("rstReady2", 32'(reqReady2), 32'd0);
        checkOutput("rstReady0", 32'(reqReady0), 32'd0);
        checkOutput("rstValid2", 32'(respValid2), 32'd0);
        checkOutput("rstRdata2", respRdata2, 32'd0);
        checkOutput("rstErr2", 32'(respErr2), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkOutput("readyAfterRst", 32'(reqReady2), 32'd1);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].write, vecs[i].addr, vecs[i].wdata,
                          vecs[i].expRdata, vecs[i].expErr, vecs[i].expLat);
            collectResponse(0, 1'b0);
        end

        // Pending load response held for five cycles while req_valid pulses.
        applyStimulus(1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 3);
        collectResponse(5, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("noSecondAccept", 32'(curValid), 32'd0);
        end

        // A request raised in the handshake cycle waits for the next IDLE cycle.
        applyStimulus(1'b0, 32'h0000_0000, 32'd0, 32'hA5A5_0000, 1'b0, 3);
        reqWrite = 1'b0;
        reqAddr  = 32'h0000_0010;
        collectResponse(0, 1'b1);
        applyStimulus(1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 3);
        collectResponse(0, 1'b0);

        // Reset during the wait states of a store must drop the store.
        checkOutput("readyBeforeStore", 32'(curReady), 32'd1);
        reqWrite = 1'b1;
        reqAddr  = 32'h0000_0020;
        reqWdata = 32'h55AA_55AA;
        reqValid = 1'b1;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstValid", 32'(curValid), 32'd0);
        checkOutput("midRstReady", 32'(curReady), 32'd0);
        checkOutput("midRstRdata", curRdata, 32'd0);
        checkOutput("midRstErr", 32'(curErr), 32'd0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        applyStimulus(1'b0, 32'h0000_0020, 32'd0, 32'h0BAD_F00D, 1'b0, 3);
        collectResponse(0, 1'b0);

        // Zero-wait-state instance.
        sel = 1'b1;
        #1;
        applyStimulus(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 1);
        collectResponse(0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0010, 32'd0, 32'hDEAD_BEEF, 1'b0, 1);
        collectResponse(0, 1'b0);
        applyStimulus(1'b0, 32'h0000_0013, 32'd0, 32'h0000_0000, 1'b1, 1);
        collectResponse(0, 1'b0);

        begin
            int  lastAccept;
            int  nAcc;
            bit  readySeen;
            lastAccept = -1;
            nAcc       = 0;
            reqWrite   = 1'b0;
            reqAddr    = 32'h0000_0010;
            reqValid   = 1'b1;
            respReady  = 1'b1;
            for (int cyc = 0; cyc < 10; cyc++) begin
                readySeen = curReady;
                @(posedge clk);
                #1;
                if (readySeen) begin
                    if (lastAccept >= 0) checkOutput("b2bGap", 32'(cyc - lastAccept), 32'd2);
                    checkOutput("b2bValid", 32'(curValid), 32'd1);
                    checkOutput("b2bRdata", curRdata, 32'hDEAD_BEEF);
                    lastAccept = cyc;
                    nAcc++;
                end
            end
            reqValid  = 1'b0;
            respReady = 1'b0;
            checkOutput("b2bAccepts", 32'(nAcc), 32'd5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
